// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory wait-state controller.
package mips_mem_pkg;

  localparam int MEMCTL_AW      = 32;
  localparam int MEMCTL_DW      = 32;
  localparam int MEMCTL_TIMEOUT = 255;

  // Returned on a read that the watchdog aborts.
  localparam logic [31:0] MEMCTL_ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } memctl_state_t;

endpackage

// File: rtl/memctl_watchdog.sv
// BUSY-cycle counter for mem_wait_ctl; flags the cycle in which the access has
// been outstanding for TIMEOUT cycles.
module memctl_watchdog
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = MEMCTL_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] count_reg;

  // count_reg holds the number of BUSY cycles already completed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (start) begin
      count_reg <= '0;
    end else if (active) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = active && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wait_ctl.sv
// Memory wait-state controller: turns single-cycle read/write intents into a held
// req/ack transaction and stalls the controller. Optional watchdog: MEMCTL_TIMEOUT_EN.
module mem_wait_ctl
  import mips_mem_pkg::*;
#(
  parameter int AW      = MEMCTL_AW,
  parameter int DW      = MEMCTL_DW,
  parameter int TIMEOUT = MEMCTL_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] writedata,
  input  logic          memread,
  input  logic          memwrite,
  output logic          stall,
  output logic [DW-1:0] readdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    mstate,
  output logic          err
);

  memctl_state_t state_reg, state_next;
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_adr_reg, mem_adr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DW-1:0] readdata_reg, readdata_next;
  logic          err_reg, err_next;
  logic          intent;
  logic          expired;

  assign intent = memread | memwrite;

`ifdef MEMCTL_TIMEOUT_EN
  logic wd_start;
  logic wd_active;

  assign wd_start  = (state_reg == IDLE) && intent;
  assign wd_active = (state_reg == BUSY);

  memctl_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .start  (wd_start),
    .active (wd_active),
    .expired(expired)
  );
`else
  logic unused_timeout;

  assign expired        = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_adr_reg   <= '0;
      mem_wdata_reg <= '0;
      readdata_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_adr_reg   <= mem_adr_next;
      mem_wdata_reg <= mem_wdata_next;
      readdata_reg  <= readdata_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_adr_next   = mem_adr_reg;
    mem_wdata_next = mem_wdata_reg;
    readdata_next  = readdata_reg;
    err_next       = err_reg;
    stall          = 1'b0;

    case (state_reg)
      IDLE: begin
        stall = intent;
        // A write wins when both intents are raised together.
        if (intent) begin
          state_next     = BUSY;
          mem_req_next   = 1'b1;
          mem_we_next    = memwrite;
          mem_adr_next   = adr;
          mem_wdata_next = writedata;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_next   = DONE;
          mem_req_next = 1'b0;
          if (!mem_we_reg) readdata_next = mem_rdata;
        end else if (expired) begin
          state_next   = DONE;
          mem_req_next = 1'b0;
          err_next     = 1'b1;
          if (!mem_we_reg) readdata_next = DW'(MEMCTL_ABORT_DATA);
        end
      end
      // The intent still visible in DONE has been served; never re-issue it.
      DONE: state_next = IDLE;
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_adr   = mem_adr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign readdata  = readdata_reg;
  assign err       = err_reg;
  assign mstate    = state_reg;

endmodule

// File: tb/tb_mem_wait_ctl.sv
// Self-checking bench for mem_wait_ctl: vector table, hand sequences and random
// accesses against a transaction-level model. Honours MEMCTL_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_mem_wait_ctl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef MEMCTL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] writedata = '0;
  logic          memread = 1'b0;
  logic          memwrite = 1'b0;
  logic          stall;
  logic [DW-1:0] readdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    mstate;
  logic          err;

  mem_wait_ctl #(
    .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
    .memread(memread), .memwrite(memwrite), .stall(stall), .readdata(readdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mstate(mstate), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd;
  logic        model_err;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rdat;
    int          exp_stall;
    int          exp_req;
    logic [31:0] exp_rd;
    int          gap;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory-side busy cycles for an access whose ack would come after lat waits.
  function automatic int busy_cycles(input int lat);
    return (TO_EN && (lat + 1 > TO)) ? TO : lat + 1;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      memread   = 1'b0;
      memwrite  = 1'b0;
      adr       = $urandom;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #3;
      chk("idle_stall", stall, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_state", mstate, 0);
      chk("idle_readdata", readdata, model_rd);
    end
  endtask

  // One access as the controller sees it: raise intent, hold it until stall drops.
  task automatic do_access(input string tag, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] wd, input int lat,
                           input logic [31:0] rdat, input int exp_stall,
                           input int exp_req, input logic [31:0] exp_rd);
    int n_stall;
    int n_req;
    bit done;
    n_stall = 0;
    n_req   = 0;
    done    = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        memread   = rd;
        memwrite  = wr;
        adr       = a;
        writedata = wd;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end else begin
        adr       = $urandom;
        writedata = $urandom;
        mem_ack   = (cyc == lat + 1) ? 1'b1 :
                    (cyc > lat + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = (cyc == lat + 1) ? rdat : $urandom;
      end
      #3;
      if (stall) n_stall++;
      if (mem_req) begin
        n_req++;
        chk({tag, "_mem_adr"}, mem_adr, a);
        chk({tag, "_mem_wdata"}, mem_wdata, wd);
        chk({tag, "_mem_we"}, mem_we, wr);
      end
      if (!stall) done = 1'b1;
    end
    if (TO_EN && (lat + 1 > TO)) model_err = 1'b1;
    chk({tag, "_completes"}, done, 1);
    chk({tag, "_stall_cycles"}, n_stall, exp_stall);
    chk({tag, "_req_cycles"}, n_req, exp_req);
    chk({tag, "_done_state"}, mstate, 2);
    chk({tag, "_done_req"}, mem_req, 0);
    chk({tag, "_readdata"}, readdata, exp_rd);
    chk({tag, "_err"}, err, model_err);
    model_rd = exp_rd;
    $display("TXN %s rd=%0b wr=%0b adr=%h stall=%0d req=%0d readdata=%h err=%0b",
             tag, rd, wr, a, n_stall, n_req, readdata, err);
  endtask

  task automatic apply_reset_idle();
    @(posedge clk); #2;
    memread  = 1'b0;
    memwrite = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_rd  = '0;
    model_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit          r_rd, r_wr;
    int          op, lat, busy;
    logic [31:0] ra, rwd, rdat, erd;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h8C12_0004, 2, 1, 32'h8C12_0004, 1};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4, 32'h5555_AAAA,
               busy_cycles(4) + 1, busy_cycles(4), 32'h8C12_0004, 0};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 1, 32'h1111_1111, 3, 2, 32'h8C12_0004, 0};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0084, 32'h0, 2, 32'h2009_0005, 4, 3, 32'h2009_0005, 2};
    tbl[4] = '{1'b1, 1'b1, 32'h0000_0090, 32'h0000_A5A5, 0, 32'hFFFF_FFFF, 2, 1, 32'h2009_0005, 1};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0094, 32'h0, 3, 32'h0000_0000, 5, 4, 32'h0000_0000, 1};

    // Asynchronous reset, then intent-only stall while held in reset.
    #1 reset = 1'b0;
    #2;
    chk("rst_state", mstate, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_adr", mem_adr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_err", err, 0);
    chk("rst_stall_idle", stall, 0);
    memread = 1'b1;
    #1;
    chk("rst_stall_follows_intent", stall, 1);
    memread = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    model_rd  = '0;
    model_err = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd,
                tbl[i].lat, tbl[i].rdat, tbl[i].exp_stall, tbl[i].exp_req, tbl[i].exp_rd);
      idle_cycles(tbl[i].gap);
    end

    for (int i = 0; i < 40; i++) begin
      op   = $urandom_range(0, 9);
      r_rd = (op < 5) || (op == 9);
      r_wr = (op >= 5);
      ra   = $urandom;
      rwd  = $urandom;
      rdat = $urandom;
      lat  = $urandom_range(0, 5);
      busy = busy_cycles(lat);
      if (r_wr) erd = model_rd;
      else if (busy < lat + 1) erd = 32'hDEAD_BEEF;
      else erd = rdat;
      do_access($sformatf("rnd%0d", i), r_rd, r_wr, ra, rwd, lat, rdat, busy + 1, busy, erd);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset dropped in the third BUSY cycle of a read.
    @(posedge clk); #1;
    memread = 1'b1; memwrite = 1'b0; adr = 32'h0000_0200; writedata = 32'h7777_0000;
    mem_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    #3;
    chk("midrst_busy_before", mstate, 1);
    reset = 1'b0;
    #1;
    chk("midrst_req", mem_req, 0);
    chk("midrst_state", mstate, 0);
    chk("midrst_adr", mem_adr, 0);
    chk("midrst_wdata", mem_wdata, 0);
    chk("midrst_readdata", readdata, 0);
    chk("midrst_err", err, 0);
    memread = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    model_rd  = '0;
    model_err = 1'b0;
    @(posedge clk); #4;
    chk("midrst_release_state", mstate, 0);
    chk("midrst_release_req", mem_req, 0);
    $display("TXN reset during BUSY: mstate=%0d mem_req=%0b", mstate, mem_req);

`ifdef MEMCTL_TIMEOUT_EN
    do_access("timeout_read", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1000, 32'h0,
              TO + 1, TO, 32'hDEAD_BEEF);
    idle_cycles(1);
    do_access("after_timeout", 1'b1, 1'b0, 32'h0000_0304, 32'h0, 1, 32'h0BAD_F00D,
              3, 2, 32'h0BAD_F00D);
    do_access("after_timeout_wr", 1'b0, 1'b1, 32'h0000_0308, 32'h0101_0101, 0, 32'h0,
              2, 1, 32'h0BAD_F00D);
    apply_reset_idle();
    @(posedge clk); #4;
    chk("timeout_err_cleared", err, 0);
`else
    @(posedge clk); #1;
    memread = 1'b1; memwrite = 1'b0; adr = 32'h0000_0300; mem_ack = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #3;
      if (i % 10 == 9) begin
        chk("noack_stall", stall, 1);
        chk("noack_req", mem_req, 1);
        chk("noack_err", err, 0);
      end
    end
    $display("TXN no-ack read: stall=%0b err=%0b after 30 BUSY cycles", stall, err);
    apply_reset_idle();
    @(posedge clk); #4;
    chk("noack_recover_state", mstate, 0);
`endif

    do_access("final_read", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h600D_0001,
              2, 1, 32'h600D_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
